apb_slave_mem: RTL and testbench

- APB3 completer with an internal register-file memory.
- Serves one of the two slave selects of the APB bridge under test.
- Samples PSEL/PENABLE/PWRITE/PADDR/PWDATA and returns PREADY/PRDATA/PSLVERR, with a parameterised wait-state count.
- Used as the response model in the bridge environment and as a standalone DUT for completer-side checks.

---
 rtl/apb_slave_mem.sv | 160 ++++++++++++++++
 tb/tb_apb_slave_mem.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a resettable register-file memory with configurable wait states.
// Optional write protection of addresses >= RO_BASE is enabled by defining APB_SLV_WPROT_EN.
module apb_slave_mem #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_CYCLES = 0,
   parameter int RO_BASE     = 192
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   output logic                  PREADY,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PSLVERR
);

   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);
`ifdef APB_SLV_WPROT_EN
   localparam logic [ADDR_WIDTH:0] RO_L = (ADDR_WIDTH + 1)'(RO_BASE);
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    write_q, write_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    err_q, err_d;
   logic                    pready_q, pready_d;
   logic                    pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
   logic                    mem_we;
   logic                    enter_resp;
   logic                    setup_err;
   logic [MEM_DEPTH-1:0]    wsel;
   logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

   // Unknown address bits are treated the same as an out-of-range address.
   always_comb begin
      setup_err = ({1'b0, PADDR} >= DEPTH_L) || $isunknown(PADDR);
`ifdef APB_SLV_WPROT_EN
      if (PWRITE && ({1'b0, PADDR} >= RO_L)) begin
         setup_err = 1'b1;
      end
`endif
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      write_d    = write_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      pready_d   = 1'b0;
      pslverr_d  = 1'b0;
      prdata_d   = prdata_q;
      mem_we     = 1'b0;
      enter_resp = 1'b0;
      case (state_q)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               write_d = PWRITE;
               addr_d  = PADDR;
               wdata_d = PWDATA;
               err_d   = setup_err;
               cnt_d   = 4'(WAIT_CYCLES);
               if (WAIT_CYCLES == 0) begin
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (!PSEL) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  enter_resp = 1'b1;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
            mem_we  = write_q && !err_q && PSEL && PENABLE;
         end
         default: state_d = IDLE;
      endcase
      // Response is registered: flags and read data load on the edge entering RESP.
      if (enter_resp) begin
         state_d   = RESP;
         pready_d  = 1'b1;
         pslverr_d = err_d;
         if (!write_d) begin
            prdata_d = err_d ? '0 : mem_q[addr_d[IDX_W-1:0]];
         end
      end
   end

   for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_wsel
      assign wsel[gi] = mem_we && (addr_q[IDX_W-1:0] == IDX_W'(gi));
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            if (wsel[i]) begin
               mem_q[i] <= wdata_q;
            end
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         err_q     <= err_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
      end
   end

   assign PREADY  = pready_q;
   assign PSLVERR = pslverr_q;
   assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed scoreboard bench for apb_slave_mem: three instances cover zero-wait,
// 3-wait with a 128-entry memory, and 4-wait with reset/abort cases.
module tb_apb_slave_mem;

   logic       clk = 1'b0;
   logic [2:0] preset = 3'b111;
   logic [2:0] psel = 3'b000;
   logic       penable = 1'b0;
   logic       pwrite = 1'b0;
   logic [7:0] paddr = 8'h00;
   logic [7:0] pwdata = 8'h00;
   logic       pready_w  [3];
   logic       pslverr_w [3];
   logic [7:0] prdata_w  [3];

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic       err;
      logic [7:0] rd;
      logic       is_rd;
      int         waits;
   } exp_t;

   exp_t exp_q[$];

`ifdef APB_SLV_WPROT_EN
   localparam bit WPROT = 1'b1;
`else
   localparam bit WPROT = 1'b0;
`endif

   always #5 clk = ~clk;

   apb_slave_mem #(.WAIT_CYCLES(0)) u_dut0 (
      .PCLK(clk), .PRESET(preset[0]), .PSEL(psel[0]), .PENABLE(penable),
      .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
      .PREADY(pready_w[0]), .PRDATA(prdata_w[0]), .PSLVERR(pslverr_w[0])
   );

   apb_slave_mem #(.WAIT_CYCLES(3), .MEM_DEPTH(128)) u_dut1 (
      .PCLK(clk), .PRESET(preset[1]), .PSEL(psel[1]), .PENABLE(penable),
      .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
      .PREADY(pready_w[1]), .PRDATA(prdata_w[1]), .PSLVERR(pslverr_w[1])
   );

   apb_slave_mem #(.WAIT_CYCLES(4)) u_dut2 (
      .PCLK(clk), .PRESET(preset[2]), .PSEL(psel[2]), .PENABLE(penable),
      .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
      .PREADY(pready_w[2]), .PRDATA(prdata_w[2]), .PSLVERR(pslverr_w[2])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      psel    = 3'b000;
      penable = 1'b0;
      tick();
   endtask

   // Full transfer: setup, ACCESS until PREADY (bounded), then the completing edge.
   task automatic xfer(input int s, input string tag, input logic wr, input logic [7:0] a,
                       input logic [7:0] d, input int waits, input logic e, input logic [7:0] rd);
      exp_t x;
      exp_t got;
      int   n;
      x.tag = tag; x.err = e; x.rd = rd; x.is_rd = !wr; x.waits = waits;
      exp_q.push_back(x);
      psel    = 3'b000;
      psel[s] = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = a;
      pwdata  = d;
      tick();
      penable = 1'b1;
      n = 0;
      while (pready_w[s] !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      got = exp_q.pop_front();
      chk({got.tag, " ready"}, 32'(pready_w[s]), 32'd1);
      chk({got.tag, " waits"}, 32'(n), 32'(got.waits));
      chk({got.tag, " pslverr"}, 32'(pslverr_w[s]), 32'(got.err));
      if (got.is_rd) begin
         chk({got.tag, " prdata"}, 32'(prdata_w[s]), 32'(got.rd));
      end
      $display("xfer %s dut%0d %s addr=%02h wdata=%02h waits=%0d pslverr=%0b prdata=%02h",
               tag, s, wr ? "WR" : "RD", a, d, n, pslverr_w[s], prdata_w[s]);
      tick();
   endtask

   initial begin
      tick();
      tick();
      preset = 3'b000;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset pready%0d", i), 32'(pready_w[i]), 32'd0);
         chk($sformatf("reset pslverr%0d", i), 32'(pslverr_w[i]), 32'd0);
         chk($sformatf("reset prdata%0d", i), 32'(prdata_w[i]), 32'd0);
      end
      bus_idle();

      // Zero-wait instance: basic and back-to-back traffic.
      xfer(0, "rd10", 1'b0, 8'h10, 8'h00, 0, 1'b0, 8'h00);
      xfer(0, "wr21", 1'b1, 8'h21, 8'h5A, 0, 1'b0, 8'h00);
      xfer(0, "rd21", 1'b0, 8'h21, 8'h00, 0, 1'b0, 8'h5A);
      xfer(0, "wr22", 1'b1, 8'h22, 8'h3C, 0, 1'b0, 8'h00);
      xfer(0, "rd21b", 1'b0, 8'h21, 8'h00, 0, 1'b0, 8'h5A);
      xfer(0, "rd22", 1'b0, 8'h22, 8'h00, 0, 1'b0, 8'h3C);
      xfer(0, "wr23", 1'b1, 8'h23, 8'h44, 0, 1'b0, 8'h00);
      chk("prdata hold", 32'(prdata_w[0]), 32'h3C);

      // PSEL+PENABLE without a setup phase must not start a transfer.
      psel    = 3'b001;
      penable = 1'b1;
      pwrite  = 1'b0;
      paddr   = 8'h21;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle penable", 32'(pready_w[0]), 32'd0);
      end
      bus_idle();

      xfer(0, "wrC0", 1'b1, 8'hC0, 8'hAA, 0, WPROT, 8'h00);
      xfer(0, "rdC0", 1'b0, 8'hC0, 8'h00, 0, 1'b0, WPROT ? 8'h00 : 8'hAA);
      xfer(0, "rdFF", 1'b0, 8'hFF, 8'h00, 0, 1'b0, 8'h00);
      bus_idle();

      // 3-wait, 128-deep instance.
      xfer(1, "wr07", 1'b1, 8'h07, 8'hC3, 3, 1'b0, 8'h00);
      xfer(1, "rd07", 1'b0, 8'h07, 8'h00, 3, 1'b0, 8'hC3);
      xfer(1, "wr90", 1'b1, 8'h90, 8'hFF, 3, 1'b1, 8'h00);
      xfer(1, "rd90", 1'b0, 8'h90, 8'h00, 3, 1'b1, 8'h00);
      xfer(1, "rd10", 1'b0, 8'h10, 8'h00, 3, 1'b0, 8'h00);
      bus_idle();

      // 4-wait instance: master abort leaves memory untouched.
      xfer(2, "wr31", 1'b1, 8'h31, 8'h55, 4, 1'b0, 8'h00);
      bus_idle();
      psel    = 3'b100;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 8'h31;
      pwdata  = 8'h66;
      tick();
      penable = 1'b1;
      tick();
      psel    = 3'b000;
      penable = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("abort pready", 32'(pready_w[2]), 32'd0);
      end
      xfer(2, "rd31", 1'b0, 8'h31, 8'h00, 4, 1'b0, 8'h55);
      xfer(2, "wr30", 1'b1, 8'h30, 8'h77, 4, 1'b0, 8'h00);
      bus_idle();

      // Reset in the second wait cycle drops the pending write and clears memory.
      psel    = 3'b100;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 8'h30;
      pwdata  = 8'h11;
      tick();
      penable = 1'b1;
      tick();
      preset[2] = 1'b1;
      tick();
      chk("rst pready", 32'(pready_w[2]), 32'd0);
      chk("rst pslverr", 32'(pslverr_w[2]), 32'd0);
      chk("rst prdata", 32'(prdata_w[2]), 32'd0);
      preset[2] = 1'b0;
      bus_idle();
      xfer(2, "rd30", 1'b0, 8'h30, 8'h00, 4, 1'b0, 8'h00);
      xfer(2, "rd31r", 1'b0, 8'h31, 8'h00, 4, 1'b0, 8'h00);
      bus_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
